// File: rtl/branch_redirect_ctrl_if.sv
// Pipeline-facing signals of the branch redirect controller: W-stage branch
// inputs in, fetch redirect / flush / kill controls out.
interface branch_redirect_ctrl_if #(
    parameter int N     = 64,
    parameter int CNT_W = 16
);
    logic             valid_W;
    logic             PCSrc_W;
    logic [N-1:0]     PCBranch_W;
    logic             stall;
    logic             PCSel;
    logic [N-1:0]     PCRedirect;
    logic             flush_F;
    logic             flush_D;
    logic             flush_E;
    logic             flush_M;
    logic             kill_W;
    logic             busy;
    logic [CNT_W-1:0] taken_count;

    // Pipeline side: drives the W-stage decision, consumes redirect controls.
    modport master (
        output valid_W, PCSrc_W, PCBranch_W, stall,
        input  PCSel, PCRedirect, flush_F, flush_D, flush_E, flush_M,
               kill_W, busy, taken_count
    );

    // Controller side.
    modport slave (
        input  valid_W, PCSrc_W, PCBranch_W, stall,
        output PCSel, PCRedirect, flush_F, flush_D, flush_E, flush_M,
               kill_W, busy, taken_count
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: accepts a taken W-stage branch, drives one
// redirect/flush cycle, then holds off further redirects for DRAIN_CYCLES
// while the pipe refills. All outputs come straight from registers.
module branch_redirect_ctrl #(
    parameter int N            = 64,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_drain;
    logic [N-1:0]     r_target;
    logic [CNT_W-1:0] r_taken;
    logic             w_accept;

    // A branch only counts when it is real, taken, and the pipe is moving.
    assign w_accept = (r_state == IDLE) && bus.valid_W && bus.PCSrc_W && !bus.stall;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; a stall freezes every state in place.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next = REDIRECT;
            REDIRECT: if (!bus.stall) w_next = DRAIN;
            DRAIN:    if (!bus.stall && r_drain == 4'd1) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Drain counter, redirect target and saturating taken count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drain  <= 4'd0;
            r_target <= '0;
            r_taken  <= '0;
        end else begin
            if (w_accept) begin
                r_target <= bus.PCBranch_W;
                if (r_taken != CNT_MAX) r_taken <= r_taken + CNT_ONE;
            end
            if (r_state == REDIRECT && !bus.stall)
                r_drain <= DRAIN_LOAD;
            else if (r_state == DRAIN && !bus.stall)
                r_drain <= r_drain - 4'd1;
        end
    end

    // Outputs decoded from state only, so no input reaches an output.
    assign bus.PCSel       = (r_state == REDIRECT);
    assign bus.flush_F     = (r_state == REDIRECT);
    assign bus.flush_D     = (r_state == REDIRECT);
    assign bus.flush_E     = (r_state == REDIRECT);
    assign bus.flush_M     = (r_state == REDIRECT);
    assign bus.kill_W      = (r_state != IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.PCRedirect  = r_target;
    assign bus.taken_count = r_taken;
endmodule
